// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: scheduler state encoding and the
// counter-width helpers reused by other image blocks.
package img_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_STREAM = STREAM,
        S_DRAIN  = DRAIN,
        S_CLEAR  = CLEAR
    } lfs_state_e;

    function automatic int credit_w(input int buffers);
        return $clog2(buffers + 1);
    endfunction

    function automatic int line_cnt_w(input int lines);
        return $clog2(lines + 1);
    endfunction

endpackage

// File: rtl/line_credit_counter.sv
// Saturating up/down credit counter; a load restores the full credit and
// an increment at full credit raises the overflow flag instead.
module line_credit_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_ovf
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         full;

    assign full    = (count_q == MAXV);
    assign o_ovf   = i_inc && !i_dec && full;
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = MAXV;
        end else if (i_inc && !i_dec && !full) begin
            count_d = count_q + 1'b1;
        end else if (i_dec && !i_inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= MAXV;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/line_feed_scheduler.sv
// Forwards whole pixel lines into the line buffers only while buffer
// credit is available, and clears the buffer block at frame end.
module line_feed_scheduler
    import img_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 8,
    parameter int LINE_WIDTH   = 512,
    parameter int BUFFER_COUNT = 4,
    parameter int OUTPUT_LINES = 3,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [PIXEL_WIDTH-1:0]               i_s_data,
    input  logic                                 i_s_valid,
    output logic                                 o_s_ready,
    output logic [PIXEL_WIDTH-1:0]               o_pixel_data,
    output logic                                 o_pixel_data_valid,
    input  logic                                 i_intr,
    output logic                                 o_lb_rst,
    output logic                                 o_busy,
    output logic                                 o_frame_done,
    output logic [$clog2(BUFFER_COUNT+1)-1:0]    o_credit,
    output logic                                 o_err
);

    localparam int CW   = credit_w(BUFFER_COUNT);
    localparam int LW   = line_cnt_w(IMAGE_HEIGHT);
    localparam int COLW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int EXPW = IMAGE_HEIGHT - OUTPUT_LINES + 1;

    localparam logic [COLW-1:0] COL_LAST  = COLW'(LINE_WIDTH - 1);
    localparam logic [LW-1:0]   LINE_LAST = LW'(IMAGE_HEIGHT - 1);
    localparam logic [LW-1:0]   WIN_EXP   = LW'(EXPW);

    lfs_state_e             state_q;
    logic [COLW-1:0]        col_q;
    logic [LW-1:0]          lines_q;
    logic [LW-1:0]          intr_cnt_q;
    logic [PIXEL_WIDTH-1:0] pix_q;
    logic                   pv_q;
    logic                   lb_rst_q;
    logic                   fd_q;
    logic                   busy_q;
    logic                   err_q;

    logic [CW-1:0] credit;
    logic          ovf;
    logic          active;
    logic          ready;
    logic          xfer;
    logic          wrap;
    logic          load;
    logic          intr_ok;
    logic          intr_bad;

    assign active   = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign ready    = (state_q == S_STREAM) && (credit != '0);
    assign xfer     = i_s_valid && ready;
    assign wrap     = xfer && (col_q == COL_LAST);
    assign load     = ((state_q == S_IDLE) && i_start) ||
                      (state_q == S_CLEAR);
    assign intr_ok  = i_intr && active && !ovf;
    assign intr_bad = (i_intr && !active) || ovf;

    line_credit_counter #(
        .MAX (BUFFER_COUNT),
        .W   (CW)
    ) u_credit (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_inc   (i_intr && active),
        .i_dec   (wrap),
        .o_count (credit),
        .o_ovf   (ovf)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            lines_q    <= '0;
            intr_cnt_q <= '0;
            pix_q      <= '0;
            pv_q       <= 1'b0;
            lb_rst_q   <= 1'b0;
            fd_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pv_q     <= xfer;
            lb_rst_q <= 1'b0;
            fd_q     <= 1'b0;
            if (xfer) begin
                pix_q <= i_s_data;
            end
            if (intr_bad) begin
                err_q <= 1'b1;
            end
            if (intr_ok) begin
                intr_cnt_q <= intr_cnt_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q    <= S_STREAM;
                        col_q      <= '0;
                        lines_q    <= '0;
                        intr_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        col_q <= wrap ? '0 : col_q + 1'b1;
                    end
                    if (wrap) begin
                        lines_q <= lines_q + 1'b1;
                        // Last line of the frame: skip DRAIN if all
                        // read windows have already come back.
                        if (lines_q == LINE_LAST) begin
                            if (intr_cnt_q >= WIN_EXP) begin
                                state_q  <= S_CLEAR;
                                lb_rst_q <= 1'b1;
                                fd_q     <= 1'b1;
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (intr_cnt_q >= WIN_EXP) begin
                        state_q  <= S_CLEAR;
                        lb_rst_q <= 1'b1;
                        fd_q     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_s_ready          = ready;
    assign o_pixel_data       = pix_q;
    assign o_pixel_data_valid = pv_q;
    assign o_lb_rst           = lb_rst_q;
    assign o_busy             = busy_q;
    assign o_frame_done       = fd_q;
    assign o_credit           = credit;
    assign o_err              = err_q;

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Self-checking bench for line_feed_scheduler: per-cycle vector table,
// pixel scoreboard and a small model of the downstream buffer block.
module tb_line_feed_scheduler;

    localparam int PW = 8;
    localparam int LWD = 4;
    localparam int BC = 4;
    localparam int OL = 3;
    localparam int IH = 6;
    localparam int CW = $clog2(BC + 1);

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [PW-1:0] i_s_data;
    logic          i_s_valid;
    logic          o_s_ready;
    logic [PW-1:0] o_pixel_data;
    logic          o_pixel_data_valid;
    logic          i_intr;
    logic          o_lb_rst;
    logic          o_busy;
    logic          o_frame_done;
    logic [CW-1:0] o_credit;
    logic          o_err;

    always #5 clk = ~clk;

    line_feed_scheduler #(
        .PIXEL_WIDTH  (PW),
        .LINE_WIDTH   (LWD),
        .BUFFER_COUNT (BC),
        .OUTPUT_LINES (OL),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_s_data           (i_s_data),
        .i_s_valid          (i_s_valid),
        .o_s_ready          (o_s_ready),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .i_intr             (i_intr),
        .o_lb_rst           (o_lb_rst),
        .o_busy             (o_busy),
        .o_frame_done       (o_frame_done),
        .o_credit           (o_credit),
        .o_err              (o_err)
    );

    typedef struct {
        logic       v;
        logic       in;
        logic       st;
        logic       rdy;
        int         cr;
        logic       ck;
        logic       pv;
        logic       bsy;
        logic       lb;
        logic       fd;
    } vec_t;

    vec_t          tbl[$];
    logic [PW-1:0] sb[$];
    logic [PW-1:0] pix = 8'h10;
    int            checks = 0;
    int            errors = 0;
    int            n_acc = 0;
    int            n_out = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic in, input logic st);
        logic          acc;
        logic [PW-1:0] e;
        i_s_valid = v;
        i_intr    = in;
        i_start   = st;
        i_s_data  = pix;
        acc = v && o_s_ready && !i_rst;
        if (acc) sb.push_back(pix);
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
            pix++;
            n_acc++;
        end
        if (o_pixel_data_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("pixel_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pixel_data", o_pixel_data, e);
            end
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;
    endtask

    function automatic void add(logic v, logic in, logic st, logic rdy,
                                int cr, logic ck, logic pv, logic bsy,
                                logic lb, logic fd);
        vec_t t;
        t.v = v; t.in = in; t.st = st; t.rdy = rdy; t.cr = cr;
        t.ck = ck; t.pv = pv; t.bsy = bsy; t.lb = lb; t.fd = fd;
        tbl.push_back(t);
    endfunction

    initial begin
        int   mpix;
        int   win;
        logic mintr;
        int   c_lb;
        int   c_fd;
        int   c_both;
        int   acc0;
        bit   done;

        // Prime, credit return, simultaneous wrap+intr, drain and clear.
        add(0, 0, 1, 1, 4, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 16; k++)
            add(1, 0, 0, (k < 16), 4 - k / 4, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++)
            add(1, 0, 0, (k < 4), (k < 4) ? 1 : 0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 1, 0, 1, 1, 1, 0, 1, 0, 0);
        add(0, 1, 0, 1, 2, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 3; k++)
            add(1, 0, 0, 1, 2, 1, 1, 1, 0, 0);
        add(1, 1, 0, 0, 2, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 4, 1, 0, 0, 0, 0);

        i_rst = 1'b1; i_start = 0; i_s_valid = 0; i_intr = 0;
        i_s_data = '0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        chk("rst_ready", o_s_ready, 0);
        chk("rst_pv", o_pixel_data_valid, 0);
        chk("rst_data", o_pixel_data, 0);
        chk("rst_lb", o_lb_rst, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_fd", o_frame_done, 0);
        chk("rst_credit", o_credit, BC);
        chk("rst_err", o_err, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].in, tbl[i].st);
            chk($sformatf("t%0d_ready", i), o_s_ready, tbl[i].rdy);
            if (tbl[i].ck)
                chk($sformatf("t%0d_credit", i), o_credit, tbl[i].cr);
            chk($sformatf("t%0d_pv", i), o_pixel_data_valid, tbl[i].pv);
            chk($sformatf("t%0d_busy", i), o_busy, tbl[i].bsy);
            chk($sformatf("t%0d_lb", i), o_lb_rst, tbl[i].lb);
            chk($sformatf("t%0d_fd", i), o_frame_done, tbl[i].fd);
            chk($sformatf("t%0d_err", i), o_err, 0);
        end
        chk("tbl_accepted", n_acc, 24);

        // Interrupt in IDLE: sticky error, credit saturated.
        cycle(1'b0, 1'b1, 1'b0);
        chk("idle_intr_err", o_err, 1);
        chk("idle_intr_credit", o_credit, BC);

        // Full frame against a model of the buffer block.
        acc0 = n_acc;
        mpix = 0; win = 0; mintr = 0;
        c_lb = 0; c_fd = 0; c_both = 0; done = 0;
        cycle(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 200 && !done; n++) begin
            cycle(1'b1, mintr, 1'b0);
            mintr = 1'b0;
            if (o_pixel_data_valid) mpix++;
            if ((mpix / LWD) >= win + OL && win < IH - OL + 1) begin
                mintr = 1'b1;
                win++;
            end
            if (o_lb_rst) c_lb++;
            if (o_frame_done) c_fd++;
            if (o_lb_rst && o_frame_done) c_both++;
            if (!o_busy) done = 1;
        end
        chk("frame_finished", done, 1);
        chk("frame_pixels", n_acc - acc0, IH * LWD);
        chk("frame_windows", win, IH - OL + 1);
        chk("frame_lb_cycles", c_lb, 1);
        chk("frame_fd_cycles", c_fd, 1);
        chk("frame_lb_fd_same", c_both, 1);
        chk("frame_busy_end", o_busy, 0);
        chk("frame_credit_end", o_credit, BC);
        chk("frame_err_sticky", o_err, 1);

        do_reset();
        chk("err_cleared", o_err, 0);

        // Reset part-way through line 3.
        cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2 * LWD + 2; k++) cycle(1'b1, 1'b0, 1'b0);
        chk("mid_credit_before", o_credit, BC - 2);
        do_reset();
        chk("mid_busy", o_busy, 0);
        chk("mid_credit", o_credit, BC);
        chk("mid_ready", o_s_ready, 0);
        chk("mid_pv", o_pixel_data_valid, 0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("restart_ready", o_s_ready, 1);
        for (int k = 0; k < LWD - 1; k++) cycle(1'b1, 1'b0, 1'b0);
        chk("restart_credit_3px", o_credit, BC);
        cycle(1'b1, 1'b0, 1'b0);
        chk("restart_credit_4px", o_credit, BC - 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("sb_empty", sb.size(), 0);
        chk("pixels_out", n_out, n_acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
